// File: rtl/pb_gpio_ext_pkg.sv
// Shared defaults, per-pin edge type and counter-width helper for the
// pb_gpio_ext pin bank.
package pb_gpio_ext_pkg;

  localparam int DEFAULT_WIDTH    = 8;
  localparam int DEFAULT_DEBOUNCE = 0;

  typedef struct packed {
    logic rise;
    logic fall;
  } pin_edge_t;

  // Debounce counter width; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pb_gpio_ext_filter.sv
// One pin: two-flop synchroniser, optional debounce counter, accepted level
// register and the rise/fall pulses produced on the edge the level updates.
module pb_gpio_ext_filter
  import pb_gpio_ext_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
  input  logic      clk_i,
  input  logic      rst_n_i,
  input  logic      pad_i,
  output logic      stable_o,
  output pin_edge_t edge_o
);

  logic s1_q;
  logic s2_q;
  logic stable_q;
  logic stable_d;
  logic accept_s;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      s1_q     <= pad_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
    end
  end

  if (DEBOUNCE_CYCLES == 0) begin : g_nofilt
    assign accept_s = 1'b1;
  end else begin : g_filt
    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Any return to the accepted level restarts the count, so short glitches never land.
    always_comb begin
      cnt_d = '0;
      if ((s2_q != stable_q) && (cnt_q != CNT_LAST)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = '0;
      end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign accept_s = (cnt_q == CNT_LAST);
  end

  always_comb begin
    stable_d = stable_q;
    if ((s2_q != stable_q) && accept_s) begin
      stable_d = s2_q;
    end else begin
      stable_d = stable_q;
    end
  end

  assign stable_o    = stable_q;
  assign edge_o.rise = stable_d & ~stable_q;
  assign edge_o.fall = ~stable_d & stable_q;

endmodule

// File: rtl/pb_gpio_ext.sv
// Parametrised Picoblaze GPIO bank: pad tri-states, per-pin filters, sticky
// edge status with write-1-to-clear, and a registered interrupt line.
module pb_gpio_ext
  import pb_gpio_ext_pkg::*;
#(
  parameter int WIDTH           = DEFAULT_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  inout  wire  [WIDTH-1:0] gpio,
  input  logic [WIDTH-1:0] gpio_oe,
  input  logic [WIDTH-1:0] gpio_enable,
  input  logic [WIDTH-1:0] gpio_data_i,
  output logic [WIDTH-1:0] gpio_data_o,
  input  logic [WIDTH-1:0] int_rise_en,
  input  logic [WIDTH-1:0] int_fall_en,
  input  logic [WIDTH-1:0] int_clear_i,
  output logic [WIDTH-1:0] int_status_o,
  output logic             int_o
);

  logic [WIDTH-1:0] stable_s;
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] fall_s;
  logic [WIDTH-1:0] event_s;
  logic [WIDTH-1:0] status_q;
  logic [WIDTH-1:0] status_d;
  logic             int_q;
  pin_edge_t        edge_s [WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign gpio[i] = (gpio_oe[i] & gpio_enable[i]) ? gpio_data_i[i] : 1'bz;

    pb_gpio_ext_filter #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_filter (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .pad_i   (gpio[i]),
      .stable_o(stable_s[i]),
      .edge_o  (edge_s[i])
    );

    assign rise_s[i] = edge_s[i].rise;
    assign fall_s[i] = edge_s[i].fall;
  end

  // Qualifiers are sampled only on the edge the filtered level moves; set beats clear.
  always_comb begin
    event_s  = ((rise_s & int_rise_en) | (fall_s & int_fall_en)) & ~gpio_oe & gpio_enable;
    status_d = (status_q & ~int_clear_i) | event_s;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      status_q <= '0;
      int_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      int_q    <= |status_q;
    end
  end

  assign gpio_data_o  = stable_s & ~gpio_oe & gpio_enable;
  assign int_status_o = status_q;
  assign int_o        = int_q;

endmodule

// File: tb/tb_pb_gpio_ext.sv
// Scoreboard bench for pb_gpio_ext: one instance without debounce, one with
// DEBOUNCE_CYCLES=4; stimulus queues expectations, a negedge monitor checks them.
module tb_pb_gpio_ext;

  logic clk_i = 1'b0;

  logic       rstn0, rstn4;
  logic [7:0] oe0, en0, dout0, ren0, fen0, clr0, pdrv0, pval0;
  logic [7:0] oe4, en4, dout4, ren4, fen4, clr4, pdrv4, pval4;
  logic [7:0] din0, st0, din4, st4;
  logic       io0, io4;
  wire  [7:0] pad0, pad4;

  typedef struct {
    int         cyc;
    int         sel;
    logic [7:0] exp;
    logic [7:0] mask;
    string      name;
  } chk_t;

  chk_t sb[$];
  int   ncnt = 0;
  int   nvec = 0;
  int   nerr = 0;

  localparam int S_DIN0 = 0, S_ST0 = 1, S_IO0 = 2, S_DIN4 = 3, S_ST4 = 4, S_IO4 = 5, S_PAD0 = 6;

  for (genvar i = 0; i < 8; i++) begin : g_pad
    assign pad0[i] = pdrv0[i] ? pval0[i] : 1'bz;
    assign pad4[i] = pdrv4[i] ? pval4[i] : 1'bz;
  end

  pb_gpio_ext #(.WIDTH(8), .DEBOUNCE_CYCLES(0)) u_d0 (
    .clk_i(clk_i), .rst_n_i(rstn0), .gpio(pad0), .gpio_oe(oe0), .gpio_enable(en0),
    .gpio_data_i(dout0), .gpio_data_o(din0), .int_rise_en(ren0), .int_fall_en(fen0),
    .int_clear_i(clr0), .int_status_o(st0), .int_o(io0)
  );

  pb_gpio_ext #(.WIDTH(8), .DEBOUNCE_CYCLES(4)) u_d4 (
    .clk_i(clk_i), .rst_n_i(rstn4), .gpio(pad4), .gpio_oe(oe4), .gpio_enable(en4),
    .gpio_data_i(dout4), .gpio_data_o(din4), .int_rise_en(ren4), .int_fall_en(fen4),
    .int_clear_i(clr4), .int_status_o(st4), .int_o(io4)
  );

  initial forever #5 clk_i = ~clk_i;

  function automatic logic [7:0] actual(input int sel);
    case (sel)
      S_DIN0:  return din0;
      S_ST0:   return st0;
      S_IO0:   return {7'd0, io0};
      S_DIN4:  return din4;
      S_ST4:   return st4;
      S_IO4:   return {7'd0, io4};
      S_PAD0:  return pad0;
      default: return 8'h00;
    endcase
  endfunction

  // Expectation for the sample taken just after the k-th rising edge from now.
  task automatic expect_after(input int k, input int sel, input logic [7:0] exp,
                              input logic [7:0] mask, input string name);
    chk_t c;
    int   pos;
    c.cyc  = ncnt + 1 + k;
    c.sel  = sel;
    c.exp  = exp;
    c.mask = mask;
    c.name = name;
    pos    = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc > c.cyc) begin
        pos = i;
        break;
      end
    end
    sb.insert(pos, c);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  initial begin : monitor
    chk_t       c;
    logic [7:0] act;
    forever begin
      @(negedge clk_i);
      ncnt = ncnt + 1;
      while (sb.size() > 0 && sb[0].cyc <= ncnt) begin
        c   = sb.pop_front();
        act = actual(c.sel);
        nvec = nvec + 1;
        if ((act & c.mask) !== (c.exp & c.mask)) begin
          nerr = nerr + 1;
          $display("FAIL %s: got %h, want %h (mask %h) at sample %0d",
                   c.name, act, c.exp, c.mask, ncnt);
        end
      end
    end
  end

  initial begin : stimulus
    rstn0 = 1'b0; oe0 = '0; en0 = '0; dout0 = '0; ren0 = '0; fen0 = '0; clr0 = '0;
    pdrv0 = 8'hFF; pval0 = '0;
    rstn4 = 1'b0; oe4 = '0; en4 = '0; dout4 = '0; ren4 = '0; fen4 = '0; clr4 = '0;
    pdrv4 = 8'hFF; pval4 = '0;

    // Reset state, during and after release with pads low
    tick(3);
    expect_after(0, S_DIN0, 8'h00, 8'hFF, "rst_din0");
    expect_after(0, S_ST0,  8'h00, 8'hFF, "rst_st0");
    expect_after(0, S_IO0,  8'h00, 8'h01, "rst_io0");
    expect_after(0, S_ST4,  8'h00, 8'hFF, "rst_st4");
    tick(1);
    rstn0 = 1'b1; rstn4 = 1'b1;
    expect_after(3, S_DIN0, 8'h00, 8'hFF, "post_rst_din0");
    expect_after(3, S_ST0,  8'h00, 8'hFF, "post_rst_st0");
    expect_after(3, S_IO0,  8'h00, 8'h01, "post_rst_io0");
    tick(4);

    // Pad drive: low nibble driven by DUT, high nibble left to the bench
    en0 = 8'hFF; oe0 = 8'h0F; dout0 = 8'hA5; pdrv0 = 8'hF0; pval0 = 8'h50;
    expect_after(0, S_PAD0, 8'h55, 8'hFF, "pad_drive");
    expect_after(3, S_DIN0, 8'h50, 8'hFF, "oe_mask_din");
    expect_after(3, S_ST0,  8'h00, 8'hFF, "no_evt_drive");
    tick(5);
    oe0 = '0; dout0 = '0; pdrv0 = 8'hFF; pval0 = '0; ren0 = 8'h04;
    tick(5);

    // Rising edge on pin2, then clear
    pval0 = 8'h04;
    expect_after(2, S_ST0,  8'h00, 8'hFF, "rise_st_early");
    expect_after(2, S_DIN0, 8'h00, 8'hFF, "rise_din_early");
    expect_after(3, S_DIN0, 8'h04, 8'hFF, "rise_din");
    expect_after(3, S_ST0,  8'h04, 8'hFF, "rise_st");
    expect_after(3, S_IO0,  8'h00, 8'h01, "rise_io_early");
    expect_after(4, S_IO0,  8'h01, 8'h01, "rise_io");
    tick(5);
    clr0 = 8'h04;
    expect_after(1, S_ST0, 8'h00, 8'hFF, "clr_st");
    expect_after(1, S_IO0, 8'h01, 8'h01, "clr_io_lag");
    expect_after(2, S_IO0, 8'h00, 8'h01, "clr_io");
    tick(1);
    clr0 = '0; ren0 = 8'h24; fen0 = 8'h20;
    tick(3);

    // Set/clear collision on pin5
    pval0 = 8'h24;
    expect_after(3, S_ST0, 8'h20, 8'hFF, "p5_rise_st");
    tick(6);
    pval0 = 8'h04;
    expect_after(3, S_ST0,  8'h20, 8'hFF, "coll_st");
    expect_after(4, S_ST0,  8'h20, 8'hFF, "coll_st_hold");
    expect_after(3, S_IO0,  8'h01, 8'h01, "coll_io");
    expect_after(5, S_IO0,  8'h01, 8'h01, "coll_io_hold");
    expect_after(3, S_DIN0, 8'h04, 8'hFF, "coll_din");
    tick(2);
    clr0 = 8'h20;
    tick(1);
    clr0 = '0;
    tick(3);
    clr0 = 8'h20;
    expect_after(1, S_ST0, 8'h00, 8'hFF, "coll_clr_st");
    expect_after(2, S_IO0, 8'h00, 8'h01, "coll_clr_io");
    tick(1);
    clr0 = '0; ren0 = 8'hFF; fen0 = 8'hFF; pdrv0 = 8'hBF; oe0 = 8'h40;
    tick(4);

    // Gating: output-mode pin6 toggled by firmware data
    dout0 = 8'h40;
    expect_after(0, S_PAD0, 8'h40, 8'h40, "oe_pad6");
    expect_after(3, S_DIN0, 8'h00, 8'h40, "oe_din6");
    expect_after(3, S_ST0,  8'h00, 8'hFF, "oe_st_rise");
    expect_after(4, S_ST0,  8'h00, 8'hFF, "oe_st_rise2");
    tick(5);
    dout0 = 8'h00;
    expect_after(3, S_ST0, 8'h00, 8'hFF, "oe_st_fall");
    tick(5);

    // Gating: disabled pin7, then enabling it while high
    en0 = 8'h7F; pval0 = 8'h84;
    expect_after(3, S_DIN0, 8'h04, 8'hFF, "dis_din7");
    expect_after(3, S_ST0,  8'h00, 8'hFF, "dis_st");
    expect_after(4, S_ST0,  8'h00, 8'hFF, "dis_st2");
    tick(5);
    en0 = 8'hFF;
    expect_after(0, S_DIN0, 8'h84, 8'hFF, "en_din7");
    expect_after(2, S_ST0,  8'h00, 8'hFF, "en_no_evt");
    expect_after(4, S_ST0,  8'h00, 8'hFF, "en_no_evt2");
    tick(5);

    // Gating: both edge enables off for pin3
    ren0 = 8'hF7; fen0 = 8'hF7; pval0 = 8'h8C;
    expect_after(3, S_DIN0, 8'h8C, 8'hFF, "noen_din3");
    expect_after(3, S_ST0,  8'h00, 8'hFF, "noen_st");
    expect_after(5, S_IO0,  8'h00, 8'h01, "noen_io");
    tick(6);

    // Debounce D=4: 3-cycle glitch rejected
    en4 = 8'hFF; ren4 = 8'h01;
    tick(2);
    pval4 = 8'h01;
    expect_after(4, S_DIN4, 8'h00, 8'h01, "glitch_din_a");
    expect_after(6, S_DIN4, 8'h00, 8'h01, "glitch_din_b");
    expect_after(8, S_DIN4, 8'h00, 8'h01, "glitch_din_c");
    expect_after(8, S_ST4,  8'h00, 8'hFF, "glitch_st");
    tick(3);
    pval4 = 8'h00;
    tick(7);

    // Debounce: held level accepted after exactly 6 edges
    pval4 = 8'h01;
    expect_after(5, S_DIN4, 8'h00, 8'h01, "deb_din_5");
    expect_after(6, S_DIN4, 8'h01, 8'h01, "deb_din_6");
    expect_after(5, S_ST4,  8'h00, 8'hFF, "deb_st_5");
    expect_after(6, S_ST4,  8'h01, 8'hFF, "deb_st_6");
    expect_after(6, S_IO4,  8'h00, 8'h01, "deb_io_6");
    expect_after(7, S_IO4,  8'h01, 8'h01, "deb_io_7");
    tick(8);
    clr4 = 8'h01;
    expect_after(1, S_ST4, 8'h00, 8'hFF, "deb_clr_st");
    expect_after(2, S_IO4, 8'h00, 8'h01, "deb_clr_io");
    tick(1);
    clr4 = '0; fen4 = 8'h01;
    tick(3);

    // Debounce: falling edge event
    pval4 = 8'h00;
    expect_after(5, S_DIN4, 8'h01, 8'h01, "fall_din_5");
    expect_after(6, S_DIN4, 8'h00, 8'h01, "fall_din_6");
    expect_after(5, S_ST4,  8'h00, 8'hFF, "fall_st_5");
    expect_after(6, S_ST4,  8'h01, 8'hFF, "fall_st_6");
    tick(8);
    clr4 = 8'h01;
    tick(1);
    clr4 = '0; ren4 = 8'h03;
    tick(3);

    // Asynchronous reset in the middle of a count
    pval4 = 8'h02;
    expect_after(6, S_ST4, 8'h02, 8'hFF, "pre_rst_st");
    tick(9);
    expect_after(0, S_ST4,  8'h02, 8'hFF, "pre_rst_st2");
    expect_after(0, S_IO4,  8'h01, 8'h01, "pre_rst_io");
    expect_after(0, S_DIN4, 8'h02, 8'hFF, "pre_rst_din");
    pval4 = 8'h03;
    tick(4);
    rstn4 = 1'b0;
    expect_after(0, S_DIN4, 8'h00, 8'hFF, "arst_din");
    expect_after(0, S_ST4,  8'h00, 8'hFF, "arst_st");
    expect_after(0, S_IO4,  8'h00, 8'h01, "arst_io");
    tick(2);
    rstn4 = 1'b1;
    expect_after(5, S_ST4,  8'h00, 8'hFF, "rel_st_5");
    expect_after(6, S_ST4,  8'h03, 8'hFF, "rel_st_6");
    expect_after(6, S_DIN4, 8'h03, 8'hFF, "rel_din_6");
    expect_after(6, S_IO4,  8'h00, 8'h01, "rel_io_6");
    expect_after(7, S_IO4,  8'h01, 8'h01, "rel_io_7");
    tick(10);

    for (int i = 0; i < 50 && sb.size() > 0; i++) begin
      @(posedge clk_i);
    end
    if (sb.size() > 0) begin
      $display("FAIL drain: got %0d pending checks, want 0", sb.size());
      nerr = nerr + sb.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
